// File: rtl/lisnoc_packet_arbiter_pkg.sv
// Shared flit-type encodings and arbiter state type for the packet arbiter slice.
// Flit type lives in the top two bits of every flit; LAST and SINGLE close a packet.
// No logic here beyond small decode helpers.
package lisnoc_packet_arbiter_pkg;

    localparam logic [1:0] FLIT_TYPE_PAYLOAD = 2'b00;
    localparam logic [1:0] FLIT_TYPE_HEADER  = 2'b01;
    localparam logic [1:0] FLIT_TYPE_LAST    = 2'b10;
    localparam logic [1:0] FLIT_TYPE_SINGLE  = 2'b11;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } arb_state_t;

    // A flit closes its packet when it is LAST or SINGLE.
    function automatic logic flit_is_last(input logic [1:0] flit_type);
        return (flit_type == FLIT_TYPE_LAST) || (flit_type == FLIT_TYPE_SINGLE);
    endfunction

    // A packet may only open with HEADER or SINGLE.
    function automatic logic flit_bad_start(input logic [1:0] flit_type);
        return (flit_type == FLIT_TYPE_PAYLOAD) || (flit_type == FLIT_TYPE_LAST);
    endfunction

endpackage

// File: rtl/lisnoc_arb_rr.sv
// Combinational round-robin picker: one-hot grant of the first request at or after i_ptr.
// Latency 0 (pure combinational). No backpressure; the caller decides when i_ptr moves.
// Ports: i_req (request vector), i_ptr (search start index), o_gnt (one-hot grant, 0 if no request).
module lisnoc_arb_rr #(
    parameter int PORTS = 4,
    parameter int PTR_W = (PORTS > 1) ? $clog2(PORTS) : 1
) (
    input  logic [PORTS-1:0] i_req,
    input  logic [PTR_W-1:0] i_ptr,
    output logic [PORTS-1:0] o_gnt
);

    logic             w_found;
    logic [PTR_W-1:0] w_idx;

    // Walk PORTS positions starting at i_ptr, wrapping PORTS-1 -> 0; first hit wins.
    always_comb begin
        o_gnt   = '0;
        w_found = 1'b0;
        w_idx   = '0;
        for (int i = 0; i < PORTS; i++) begin
            w_idx = PTR_W'((int'(i_ptr) + i) % PORTS);
            if (!w_found && i_req[w_idx]) begin
                o_gnt[w_idx] = 1'b1;
                w_found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/lisnoc_packet_arbiter.sv
// Packet-granular round-robin arbiter sharing one flit link among PORTS packet buffers.
// Latency 0: flit mux is combinational from the granted port; no storage in the datapath.
// Backpressure: out_ready gates in_ready of the granted port only; with it low, grant and lock hold.
// Ports: clk/rst (sync, active-high); in_flit/in_valid/in_ready per requester; out_flit/out_valid/
// out_ready downstream; out_grant one-hot grant; out_busy while locked; err_proto bad packet start.
module lisnoc_packet_arbiter
    import lisnoc_packet_arbiter_pkg::*;
#(
    parameter int data_width = 32,
    parameter int PORTS      = 4
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [PORTS*(data_width+2)-1:0]  in_flit,
    input  logic [PORTS-1:0]                 in_valid,
    output logic [PORTS-1:0]                 in_ready,
    output logic [data_width+1:0]            out_flit,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic [PORTS-1:0]                 out_grant,
    output logic                             out_busy,
    output logic                             err_proto
);

    localparam int FLIT_W = data_width + 2;
    localparam int PTR_W  = (PORTS > 1) ? $clog2(PORTS) : 1;

    arb_state_t       r_state;
    arb_state_t       w_state_nxt;
    logic [PORTS-1:0] r_grant_q;
    logic [PTR_W-1:0] r_prio_ptr;

    logic [PORTS-1:0] w_pick;
    logic [PORTS-1:0] w_grant;
    logic [PTR_W-1:0] w_gnt_idx;
    logic [PTR_W-1:0] w_ptr_nxt;
    logic [1:0]       w_type;
    logic             w_xfer;
    logic             w_last;
    logic             w_latch;
    logic             w_advance;

    lisnoc_arb_rr #(
        .PORTS (PORTS),
        .PTR_W (PTR_W)
    ) u_arb_rr (
        .i_req (in_valid),
        .i_ptr (r_prio_ptr),
        .o_gnt (w_pick)
    );

    // While locked the stored grant wins regardless of new requests.
    assign w_grant = (r_state == ST_LOCKED) ? r_grant_q : w_pick;

    // One-hot AND-OR mux; grant is at most one-hot so the OR never mixes ports.
    always_comb begin
        out_flit = '0;
        for (int i = 0; i < PORTS; i++) begin
            out_flit = out_flit | (in_flit[i*FLIT_W +: FLIT_W] & {FLIT_W{w_grant[i]}});
        end
    end

    assign out_grant = w_grant;
    assign out_valid = |(in_valid & w_grant);
    assign in_ready  = w_grant & {PORTS{out_ready}};
    assign out_busy  = (r_state == ST_LOCKED);
    assign w_xfer    = out_valid & out_ready;
    assign w_type    = out_flit[FLIT_W-1 -: 2];
    assign w_last    = flit_is_last(w_type);

    // Index of the port currently granted, used to move the priority pointer past it.
    always_comb begin
        w_gnt_idx = '0;
        for (int i = 0; i < PORTS; i++) begin
            if (w_grant[i]) begin
                w_gnt_idx = PTR_W'(i);
            end
        end
    end

    assign w_ptr_nxt = (int'(w_gnt_idx) == PORTS - 1) ? '0 : w_gnt_idx + 1'b1;

    always_comb begin
        w_state_nxt = r_state;
        w_latch     = 1'b0;
        w_advance   = 1'b0;
        err_proto   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_xfer) begin
                    // Bad start is flagged but the flit still goes through and the
                    // last/non-last rule decides the next state as usual.
                    err_proto = flit_bad_start(w_type);
                    if (w_last) begin
                        w_advance = 1'b1;
                    end else begin
                        w_latch     = 1'b1;
                        w_state_nxt = ST_LOCKED;
                    end
                end
            end
            ST_LOCKED: begin
                // HEADER inside a packet is not checked; only LAST/SINGLE ends the lock.
                if (w_xfer && w_last) begin
                    w_advance   = 1'b1;
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_grant_q  <= '0;
            r_prio_ptr <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_latch) begin
                r_grant_q <= w_grant;
            end
            if (w_advance) begin
                r_prio_ptr <= w_ptr_nxt;
            end
        end
    end

endmodule

// File: tb/tb_lisnoc_packet_arbiter.sv
module tb_lisnoc_packet_arbiter;

    localparam int DW = 32;
    localparam int NP = 4;
    localparam int FW = DW + 2;

    localparam logic [1:0] T_PAY = 2'b00;
    localparam logic [1:0] T_HDR = 2'b01;
    localparam logic [1:0] T_LST = 2'b10;
    localparam logic [1:0] T_SGL = 2'b11;

    logic             clk = 1'b0;
    logic             rst;
    logic [NP*FW-1:0] in_flit;
    logic [NP-1:0]    in_valid;
    logic [NP-1:0]    in_ready;
    logic [FW-1:0]    out_flit;
    logic             out_valid;
    logic             out_ready;
    logic [NP-1:0]    out_grant;
    logic             out_busy;
    logic             err_proto;

    lisnoc_packet_arbiter #(.data_width(DW), .PORTS(NP)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_flit   (in_flit),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_flit  (out_flit),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_grant (out_grant),
        .out_busy  (out_busy),
        .err_proto (err_proto)
    );

    always #5 clk = ~clk;

    typedef struct {
        int            port;
        logic [FW-1:0] flit;
        logic          err;
        logic          busy;
    } exp_t;

    exp_t          exp_q [$];
    logic [FW-1:0] src_q [NP][$];
    logic [NP-1:0] stall;
    int            n_checks = 0;
    int            n_errors = 0;
    int            busy_cnt = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [FW-1:0] mk(input logic [1:0] t, input int port, input int pkt, input int idx);
        return {t, 8'(port), 8'(pkt), 8'(idx), 8'h5A};
    endfunction

    function automatic logic [1:0] pkt_type(input int n, input int idx);
        if (n == 1)       return T_SGL;
        if (idx == 0)     return T_HDR;
        if (idx == n - 1) return T_LST;
        return T_PAY;
    endfunction

    task automatic push_pkt(input int port, input int pkt, input int n);
        for (int k = 0; k < n; k++) src_q[port].push_back(mk(pkt_type(n, k), port, pkt, k));
    endtask

    // Well-formed packet: no error, busy on every flit after the first.
    task automatic expect_pkt(input int port, input int pkt, input int n);
        exp_t e;
        for (int k = 0; k < n; k++) begin
            e.port = port; e.flit = mk(pkt_type(n, k), port, pkt, k);
            e.err = 1'b0;  e.busy = (k != 0);
            exp_q.push_back(e);
        end
    endtask

    task automatic expect_flit(input int port, input logic [FW-1:0] f, input logic err, input logic busy);
        exp_t e;
        e.port = port; e.flit = f; e.err = err; e.busy = busy;
        exp_q.push_back(e);
    endtask

    task automatic drive();
        for (int i = 0; i < NP; i++) begin
            in_valid[i] = (src_q[i].size() > 0) && !stall[i];
            in_flit[i*FW +: FW] = (src_q[i].size() > 0) ? src_q[i][0] : '0;
        end
    endtask

    // One clock: drive sources, compare any transfer against the scoreboard, pop accepted flits.
    task automatic step();
        exp_t e;
        drive();
        @(negedge clk);
        if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_xfer", 64'(out_grant), 64'(0));
            end else begin
                e = exp_q.pop_front();
                chk("grant",    64'(out_grant), 64'(1 << e.port));
                chk("flit",     64'(out_flit),  64'(e.flit));
                chk("err",      64'(err_proto), 64'(e.err));
                chk("busy",     64'(out_busy),  64'(e.busy));
                chk("in_ready", 64'(in_ready),  64'(1 << e.port));
            end
        end else begin
            chk("err_no_xfer", 64'(err_proto), 64'(0));
        end
        for (int i = 0; i < NP; i++) begin
            if (in_valid[i] && in_ready[i]) void'(src_q[i].pop_front());
        end
        if (out_busy) busy_cnt++;
        @(posedge clk);
        #1;
    endtask

    task automatic run(input int max_cycles);
        int n = 0;
        while (exp_q.size() != 0 && n < max_cycles) begin
            step();
            n++;
        end
        chk("drain", 64'(exp_q.size()), 64'(0));
    endtask

    task automatic do_reset();
        rst = 1'b1;
        stall = '0;
        for (int i = 0; i < NP; i++) src_q[i].delete();
        exp_q.delete();
        drive();
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        drive();
        @(negedge clk);
        chk("rst_valid",    64'(out_valid), 64'(0));
        chk("rst_grant",    64'(out_grant), 64'(0));
        chk("rst_busy",     64'(out_busy),  64'(0));
        chk("rst_err",      64'(err_proto), 64'(0));
        chk("rst_in_ready", 64'(in_ready),  64'(0));
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; out_ready = 1'b1; stall = '0; in_valid = '0; in_flit = '0;
        do_reset();

        // 1: single-flit packet on port 0, then ptr=1 makes port 1 win over port 0.
        push_pkt(0, 0, 1); expect_pkt(0, 0, 1);
        step();
        push_pkt(0, 1, 1); push_pkt(1, 1, 1);
        expect_pkt(1, 1, 1); expect_pkt(0, 1, 1);
        run(10);

        // 2: all ports with 3-flit packets; port 0 has two. Order 0,1,2,3,0, busy 2 per packet.
        do_reset();
        for (int p = 0; p < NP; p++) push_pkt(p, 2, 3);
        push_pkt(0, 3, 3);
        for (int p = 0; p < NP; p++) expect_pkt(p, 2, 3);
        expect_pkt(0, 3, 3);
        busy_cnt = 0;
        run(40);
        chk("busy_cycles", 64'(busy_cnt), 64'(10));

        // 3: ptr=1, port 2 wins over port 0, then stalls 3 cycles while locked.
        push_pkt(2, 4, 3); push_pkt(0, 4, 1);
        expect_pkt(2, 4, 3); expect_pkt(0, 4, 1);
        step();
        stall[2] = 1'b1;
        for (int k = 0; k < 3; k++) begin
            drive(); #1;
            chk("stall_valid", 64'(out_valid), 64'(0));
            chk("stall_grant", 64'(out_grant), 64'(4'b0100));
            chk("stall_busy",  64'(out_busy),  64'(1));
            step();
        end
        stall[2] = 1'b0;
        run(20);

        // 4: out_ready low 5 cycles in the middle of port 1's packet; port 3 waits.
        push_pkt(1, 5, 4); push_pkt(3, 5, 1);
        expect_pkt(1, 5, 4); expect_pkt(3, 5, 1);
        step(); step();
        out_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            drive(); #1;
            chk("hold_flit",     64'(out_flit),  64'(mk(T_PAY, 1, 5, 2)));
            chk("hold_in_ready", 64'(in_ready),  64'(0));
            chk("hold_grant",    64'(out_grant), 64'(4'b0010));
            chk("hold_busy",     64'(out_busy),  64'(1));
            step();
        end
        out_ready = 1'b1;
        run(20);

        // 5: bad packet starts. LAST alone stays idle; PAYLOAD start locks.
        src_q[3].push_back(mk(T_LST, 3, 6, 0));
        expect_flit(3, mk(T_LST, 3, 6, 0), 1'b1, 1'b0);
        run(10);
        drive(); #1;
        chk("last_start_busy", 64'(out_busy), 64'(0));
        src_q[1].push_back(mk(T_PAY, 1, 7, 0));
        src_q[1].push_back(mk(T_LST, 1, 7, 1));
        expect_flit(1, mk(T_PAY, 1, 7, 0), 1'b1, 1'b0);
        expect_flit(1, mk(T_LST, 1, 7, 1), 1'b0, 1'b1);
        run(10);

        // 6: ptr=2, port 2 locks, reset mid-packet; ptr back to 0, leftovers flag errors.
        push_pkt(2, 8, 4);
        expect_pkt(2, 8, 4);
        step(); step();
        rst = 1'b1;
        for (int i = 0; i < NP; i++) src_q[i].delete();
        exp_q.delete();
        drive();
        @(posedge clk); #1;
        rst = 1'b0;
        drive(); #1;
        chk("mid_rst_busy",  64'(out_busy),  64'(0));
        chk("mid_rst_grant", 64'(out_grant), 64'(0));
        chk("mid_rst_valid", 64'(out_valid), 64'(0));
        src_q[2].push_back(mk(T_PAY, 2, 8, 2));
        src_q[2].push_back(mk(T_LST, 2, 8, 3));
        push_pkt(0, 9, 1);
        expect_pkt(0, 9, 1);
        expect_flit(2, mk(T_PAY, 2, 8, 2), 1'b1, 1'b0);
        expect_flit(2, mk(T_LST, 2, 8, 3), 1'b0, 1'b1);
        run(10);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
